// File: rtl/fdc_host_seq.sv
// Host-side uPD765 command sequencer: polls the MSR and runs the command,
// parameter, execution-read and result-read phases on the FDC CPU bus.
//
// state   | meaning
// IDLE    | waiting for start
// POLL    | one MSR read, then branch on phase and MSR bits
// WR_BYTE | one data-port write (command or parameter byte)
// EXEC_RD | one execution-phase data read
// RES_RD  | one result-phase data read
// FINISH  | done pulse, back to IDLE
module fdc_host_seq #(
    parameter int unsigned MAX_PARAMS    = 8,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned POLL_TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [63:0] params,
    input  logic [3:0]  nparams,
    input  logic        exec_rd,
    input  logic [15:0] exec_len,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [55:0] results,
    output logic [2:0]  nresults,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        fdc_ce,
    output logic        fdc_a0,
    output logic        fdc_rd_n,
    output logic        fdc_wr_n,
    output logic [7:0]  fdc_dout,
    input  logic [7:0]  fdc_din
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_POLL = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_RES  = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam logic [1:0] PH_WRITE  = 2'd0;
    localparam logic [1:0] PH_EXEC   = 2'd1;
    localparam logic [1:0] PH_RESULT = 2'd2;

    localparam logic [7:0]  CYC_LAST_LOW = 8'(STROBE_CYCLES);
    localparam logic [7:0]  CYC_RECOV    = 8'(STROBE_CYCLES + 1);
    localparam logic [15:0] TMO          = 16'(POLL_TIMEOUT);
    localparam logic [3:0]  MAXP         = 4'(MAX_PARAMS);

    logic [2:0]  state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [7:0]  cyc_q, cyc_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  np_q, np_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [63:0] params_q, params_d;
    logic        exec_rd_q, exec_rd_d;
    logic [15:0] exec_len_q, exec_len_d;
    logic [15:0] ecnt_q, ecnt_d;
    logic [15:0] poll_q, poll_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        error_q, error_d;
    logic [55:0] results_q, results_d;
    logic [2:0]  nres_q, nres_d;
    logic [7:0]  data_out_q, data_out_d;

    logic       in_access, acc_end, strobe_low, stall;
    logic       rfm, dio, exm, msr_busy;
    logic [2:0] pidx;
    logic [7:0] wr_byte;

    assign rfm      = rdata_q[7];
    assign dio      = rdata_q[6];
    assign exm      = rdata_q[5];
    assign msr_busy = rdata_q[4];

    assign in_access = (state_q == S_POLL) || (state_q == S_WR) ||
                       (state_q == S_EXEC) || (state_q == S_RES);
    assign acc_end    = in_access && (cyc_q == CYC_RECOV);
    assign strobe_low = in_access && (cyc_q != 8'd0) && (cyc_q != CYC_RECOV);

    // Byte index 0 is the command, index k is parameter k-1.
    assign pidx    = idx_q[2:0] - 3'd1;
    assign wr_byte = (idx_q == 4'd0) ? cmd_q : params_q[{pidx, 3'b000} +: 8];

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cyc_d      = cyc_q;
        idx_d      = idx_q;
        np_d       = np_q;
        cmd_d      = cmd_q;
        params_d   = params_q;
        exec_rd_d  = exec_rd_q;
        exec_len_d = exec_len_q;
        ecnt_d     = ecnt_q;
        poll_d     = poll_q;
        rdata_d    = rdata_q;
        error_d    = error_q;
        results_d  = results_q;
        nres_d     = nres_q;
        data_out_d = data_out_q;
        stall      = 1'b0;

        if (in_access) begin
            cyc_d = acc_end ? 8'd0 : cyc_q + 8'd1;
            if (cyc_q == CYC_LAST_LOW && state_q != S_WR) begin
                rdata_d = fdc_din;
                if (state_q == S_EXEC) data_out_d = fdc_din;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_d      = cmd;
                    params_d   = params;
                    np_d       = (nparams > MAXP) ? MAXP : nparams;
                    exec_rd_d  = exec_rd;
                    exec_len_d = exec_len;
                    nres_d     = 3'd0;
                    error_d    = 1'b0;
                    idx_d      = 4'd0;
                    poll_d     = 16'd0;
                    ecnt_d     = 16'd0;
                    cyc_d      = 8'd0;
                    phase_d    = PH_WRITE;
                    state_d    = S_POLL;
                end
            end
            S_POLL: begin
                if (acc_end) begin
                    case (phase_q)
                        PH_WRITE: begin
                            if (rfm && !dio) state_d = S_WR;
                            // FDC left the command phase early: drop remaining bytes.
                            else if (dio) phase_d = (exec_rd_q && exm && exec_len_q != 16'd0) ? PH_EXEC : PH_RESULT;
                            else stall = 1'b1;
                        end
                        PH_EXEC: begin
                            if (exm && dio && rfm) state_d = S_EXEC;
                            else if (!exm) phase_d = PH_RESULT;
                            else stall = 1'b1;
                        end
                        default: begin
                            if (!msr_busy) state_d = S_FIN;
                            else if (rfm && dio) state_d = S_RES;
                            else stall = 1'b1;
                        end
                    endcase
                    if (stall) begin
                        if (poll_q + 16'd1 == TMO) begin
                            error_d = 1'b1;
                            state_d = S_FIN;
                        end else begin
                            poll_d = poll_q + 16'd1;
                        end
                    end
                end
            end
            S_WR: begin
                if (acc_end) begin
                    poll_d  = 16'd0;
                    idx_d   = idx_q + 4'd1;
                    state_d = S_POLL;
                    if (idx_q == np_q)
                        phase_d = (exec_rd_q && exec_len_q != 16'd0) ? PH_EXEC : PH_RESULT;
                end
            end
            S_EXEC: begin
                if (acc_end) begin
                    poll_d  = 16'd0;
                    ecnt_d  = ecnt_q + 16'd1;
                    state_d = S_POLL;
                    if (ecnt_q + 16'd1 == exec_len_q) phase_d = PH_RESULT;
                end
            end
            S_RES: begin
                if (acc_end) begin
                    poll_d  = 16'd0;
                    state_d = S_POLL;
                    if (nres_q != 3'd7) begin
                        results_d[{nres_q, 3'b000} +: 8] = rdata_q;
                        nres_d = nres_q + 3'd1;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_WRITE;
            cyc_q      <= 8'd0;
            idx_q      <= 4'd0;
            np_q       <= 4'd0;
            cmd_q      <= 8'd0;
            params_q   <= 64'd0;
            exec_rd_q  <= 1'b0;
            exec_len_q <= 16'd0;
            ecnt_q     <= 16'd0;
            poll_q     <= 16'd0;
            rdata_q    <= 8'd0;
            error_q    <= 1'b0;
            results_q  <= 56'd0;
            nres_q     <= 3'd0;
            data_out_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cyc_q      <= cyc_d;
            idx_q      <= idx_d;
            np_q       <= np_d;
            cmd_q      <= cmd_d;
            params_q   <= params_d;
            exec_rd_q  <= exec_rd_d;
            exec_len_q <= exec_len_d;
            ecnt_q     <= ecnt_d;
            poll_q     <= poll_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
            results_q  <= results_d;
            nres_q     <= nres_d;
            data_out_q <= data_out_d;
        end
    end

    // Bus controls decode straight from reset flops so reset releases the strobes at once.
    assign busy       = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done       = (state_q == S_FIN);
    assign error      = error_q;
    assign results    = results_q;
    assign nresults   = nres_q;
    assign data_out   = data_out_q;
    assign data_valid = (state_q == S_EXEC) && (cyc_q == CYC_RECOV);
    assign fdc_ce     = in_access && (cyc_q != CYC_RECOV);
    assign fdc_a0     = in_access && (state_q != S_POLL);
    assign fdc_rd_n   = !(strobe_low && state_q != S_WR);
    assign fdc_wr_n   = !(strobe_low && state_q == S_WR);
    assign fdc_dout   = (state_q == S_WR) ? wr_byte : 8'd0;

endmodule

// File: doc/fdc_host_seq.md
# fdc_host_seq

Host-side command sequencer for the NEC765-compatible floppy controller. Takes one complete command (opcode plus up to 8 parameter bytes) and runs the full µPD765 host protocol on the FDC's CPU bus: MSR polling, command and parameter writes, execution-phase data reads and result-phase reads. It is the initiator for the FDC's data/status port. It sits between a boot/test controller or a DMA-style loader and the FDC, in place of Z80 firmware.

## Interface
- `MAX_PARAMS`, 8, capacity of the parameter vector; `nparams` values above it are clamped.
- `STROBE_CYCLES`, 2, cycles `fdc_rd_n`/`fdc_wr_n` are held low per access; minimum 2.
- `POLL_TIMEOUT`, 65535, consecutive MSR reads without progress before the sequencer aborts.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: command request, sampled only in IDLE.
- `cmd` in 8: command byte.
- `params` in 64: parameter byte i is at [8i+7:8i].
- `nparams` in 4: number of parameter bytes.
- `exec_rd` in 1: the command has an execution read phase.
- `exec_len` in 16: maximum execution bytes to read.
- `busy` out 1: a sequence is in progress.
- `done` out 1: one-cycle pulse at the end of a sequence.
- `error` out 1: timeout flag, valid with `done`, held until the next `start`.
- `results` out 56: result byte i is at [8i+7:8i].
- `nresults` out 3: result bytes captured, saturating at 7.
- `data_out` out 8: execution-phase byte.
- `data_valid` out 1: one-cycle pulse per execution byte.
- `fdc_ce` out 1, `fdc_a0` out 1, `fdc_rd_n` out 1, `fdc_wr_n` out 1: FDC bus controls.
- `fdc_dout` out 8: data driven to the FDC.
- `fdc_din` in 8: data read from the FDC.

## Operation
- MSR bits are `rfm`[7], `dio`[6], `exm`[5] and `busy`[4]. `a0`=0 selects MSR and `a0`=1 selects the data port.
- Bus access is STROBE_CYCLES+2 cycles:
  - 1 setup cycle: `ce`=1, `a0` and `fdc_dout` valid, strobe high.
  - STROBE_CYCLES cycles with the strobe low. `fdc_din` is sampled on the last low cycle.
  - 1 recovery cycle: strobe high, `ce`=0.
  - `fdc_rd_n` and `fdc_wr_n` are never low at the same time.
- States: IDLE, POLL, WR_BYTE, EXEC_RD, RES_RD, FINISH.
- **IDLE**
  - On `start`, latch `cmd`, `params`, min(`nparams`,MAX_PARAMS), `exec_rd` and `exec_len`.
  - Clear `nresults`, `error`, the byte index and the poll counter, then go to POLL with phase=WRITE.
- **POLL** reads the MSR, then acts by phase:
  - **phase WRITE**
    - `rfm`=1 and `dio`=0: go to WR_BYTE.
    - `dio`=1: the FDC has entered result or execution phase early. Drop the remaining bytes; phase becomes EXEC if `exec_rd` is set and `exm`=1, otherwise RESULT.
  - **phase EXEC**
    - `exm`=1, `dio`=1 and `rfm`=1: go to EXEC_RD.
    - `exm`=0: phase becomes RESULT.
  - **phase RESULT**
    - `busy`=0: go to FINISH.
    - `rfm`=1 and `dio`=1: go to RES_RD.
  - Any other MSR value increments the poll counter. When it reaches POLL_TIMEOUT, set `error` and go to FINISH. Any successful data access clears the counter.
- **WR_BYTE**
  - Writes the command byte, then parameters 0..n-1, with `a0`=1.
  - After the last byte, phase becomes EXEC if `exec_rd` is set, otherwise RESULT.
- **EXEC_RD**
  - Data read with `a0`=1. Drives `data_out` and pulses `data_valid` in the recovery cycle.
  - After `exec_len` bytes, phase becomes RESULT.
  - `exec_len`=0 skips the execution phase.
- **RES_RD**
  - Data read; the byte is stored at index `nresults`.
  - Bytes beyond the 7th are read but discarded, and `nresults` stays at 7.
- **FINISH**: pulse `done` for one cycle, drop `busy` in the same cycle, return to IDLE.
- `nparams`=0 writes only the command byte.

## Timing
- Reset values:
  - `busy`, `done`, `error`, `data_valid`, `fdc_ce`, `fdc_a0`: 0.
  - `fdc_rd_n`, `fdc_wr_n`: 1.
  - `fdc_dout`, `data_out`, `results`: 0.
  - `nresults`: 0.
  - State: IDLE.
- Reset mid-sequence forces these values immediately. Strobes go high asynchronously and no partial access completes.
- `busy` rises the cycle after `start` is sampled. The first MSR setup cycle is that same cycle.
- `start` while `busy` is ignored. `start` in the FINISH cycle is ignored; a new command needs `start` in IDLE.
- Consecutive accesses are back-to-back with no idle cycle between them.
- `results` and `nresults` are stable from `done` until the next accepted `start`.

## Test plan
- **SPECIFY.** Bench: FDC model, `cmd`=0x03, params 0xA1,0x03, `nparams`=2. Required: bus writes 0x03, 0xA1, 0x03 with `a0`=1, each preceded by an MSR read with `a0`=0. Then `done` with `nresults`=0 and `error`=0.
- **SENSE_DRIVE_STATUS.** `cmd`=0x04, param 0x00, `disk_wp`=01. Required: `nresults`=1 and results[0]=0x40.
- **READ_DATA.** `cmd`=0x46, params 00,00,00,C1,02,C1,2A,FF, `exec_rd`=1, `exec_len`=512. Required: 512 `data_valid` pulses, all with `data_out`=0xE5. Then `nresults`=7, results[0]=0x20 and results[6]=0x02.
- **Invalid command.** `cmd`=0x1F, `nparams`=2. Required: after the command byte, `dio`=1 is seen and no parameters are written. results[0]=0x80 and `nresults`=1.
- **Timeout.** `POLL_TIMEOUT`=16, `fdc_din` stuck at 0x00. Required: exactly 16 MSR reads, then `done` with `error`=1, and `busy`=0 the same cycle.
- **Reset mid-execution.** Assert `rst_n`=0 during the 100th execution byte with `fdc_rd_n` low. Required: all outputs are at their reset values within the same cycle. After release, a SPECIFY command completes normally.
